// File: rtl/sky130_ram_1p_host_adapter_pkg.sv
// Shared types and helpers for the host-side adapter in front of the sky130 1p RAM.
// Byte-mask classification is what decides between a direct write and a read-modify-write.
package ram_1p_host_pkg;

  localparam int ByteW = 8;

  typedef enum logic {
    IDLE,
    RMW_MERGE
  } state_e;

  typedef enum logic [1:0] {
    BYTE_NONE,
    BYTE_PARTIAL,
    BYTE_FULL
  } byte_class_e;

  function automatic byte_class_e byte_mask_expand(input logic [ByteW-1:0] mask);
    if (&mask) begin
      return BYTE_FULL;
    end
    if (|mask) begin
      return BYTE_PARTIAL;
    end
    return BYTE_NONE;
  endfunction

endpackage

// File: rtl/sky130_ram_1p_host_adapter_rsp_fifo.sv
// Ordered response queue for the host adapter; one push and one pop per cycle.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module ram_1p_rsp_fifo
  import ram_1p_host_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 2,
  localparam int PtrW = $clog2(Depth),
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wrPtr_q, rdPtr_q;
  logic [CntW-1:0]  count_q;
  logic             pushEn, popEn, full;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign popEn   = pop_i & ~empty_o;
  assign pushEn  = push_i & (~full | popEn);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) begin
        wrPtr_q <= incPtr(wrPtr_q);
      end
      if (popEn) begin
        rdPtr_q <= incPtr(rdPtr_q);
      end
      count_q <= count_q + CntW'(pushEn) - CntW'(popEn);
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/sky130_ram_1p_host_adapter.sv
// Host req/gnt + rvalid/rready front end for the sky130 single-port RAM.
// Sub-byte writes are turned into a RAM read followed by a merged whole-byte write.
module sky130_ram_1p_host_adapter
  import ram_1p_host_pkg::*;
#(
  parameter int Width    = 32,
  parameter int Depth    = 512,
  parameter int RspDepth = 2,
  localparam int Aw      = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             we_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam int NumBytes = Width / ByteW;
  localparam int CntW     = $clog2(RspDepth + 1);

  typedef struct packed {
    logic [Width-1:0] rdata;
  } rsp_t;

  state_e           state_q, state_d;
  logic [Aw-1:0]    addr_q;
  logic [Width-1:0] wdata_q, wmask_q;
  logic             pendValid_q, pendValid_d;
  logic             pendIsRead_q, pendIsRead_d;
  logic             captureRmw, creditOk, pop, anyPartial, fifoEmpty;
  logic [Width-1:0] fullMask, touchedMask, mergedData;
  logic [CntW-1:0]  fifoCnt;
  int               occupancy;
  rsp_t             pushRsp, headRsp;

  assign pop      = rvalid_o & rready_i;
  assign rvalid_o = ~fifoEmpty;
  assign rdata_o  = headRsp.rdata;

  always_comb begin
    anyPartial  = 1'b0;
    fullMask    = '0;
    touchedMask = '0;
    for (int b = 0; b < NumBytes; b++) begin
      anyPartial = anyPartial |
                   (byte_mask_expand(wmask_i[b*ByteW +: ByteW]) == BYTE_PARTIAL);
      fullMask[b*ByteW +: ByteW] =
          {ByteW{byte_mask_expand(wmask_i[b*ByteW +: ByteW]) == BYTE_FULL}};
      touchedMask[b*ByteW +: ByteW] = {ByteW{|wmask_q[b*ByteW +: ByteW]}};
    end
  end

  assign mergedData = (ram_rdata_i & ~wmask_q) | (wdata_q & wmask_q);

  // The in-flight response counts against the queue even before it is pushed.
  always_comb begin
    occupancy = int'(fifoCnt) + int'(pendValid_q) - int'(pop);
    creditOk  = occupancy < RspDepth;
  end

  always_comb begin
    state_d      = state_q;
    gnt_o        = 1'b0;
    ram_req_o    = 1'b0;
    ram_write_o  = 1'b0;
    ram_addr_o   = addr_i;
    ram_wdata_o  = wdata_i;
    ram_wmask_o  = '0;
    captureRmw   = 1'b0;
    pendIsRead_d = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        IDLE: begin
          if (req_i && creditOk) begin
            if (!we_i) begin
              gnt_o        = 1'b1;
              ram_req_o    = 1'b1;
              pendIsRead_d = 1'b1;
            end else if (anyPartial) begin
              ram_req_o  = 1'b1;
              captureRmw = 1'b1;
              state_d    = RMW_MERGE;
            end else begin
              gnt_o       = 1'b1;
              ram_req_o   = |fullMask;
              ram_write_o = |fullMask;
              ram_wmask_o = fullMask;
            end
          end
        end
        RMW_MERGE: begin
          gnt_o       = 1'b1;
          ram_req_o   = 1'b1;
          ram_write_o = 1'b1;
          ram_addr_o  = addr_q;
          ram_wdata_o = mergedData;
          ram_wmask_o = touchedMask;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pendValid_d = gnt_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pendValid_q  <= 1'b0;
      pendIsRead_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pendValid_q  <= pendValid_d;
      pendIsRead_q <= pendIsRead_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (captureRmw) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      wmask_q <= wmask_i;
    end
  end

  // RAM read data is only valid the cycle after the read, which is the push cycle.
  assign pushRsp.rdata = pendIsRead_q ? ram_rdata_i : '0;

  ram_1p_rsp_fifo #(
    .Width($bits(rsp_t)),
    .Depth(RspDepth)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (pendValid_q),
    .wdata_i(pushRsp),
    .pop_i  (pop),
    .count_o(fifoCnt),
    .empty_o(fifoEmpty),
    .head_o (headRsp)
  );

endmodule

// File: tb/tb_sky130_ram_1p_host_adapter.sv
// Self-checking bench for sky130_ram_1p_host_adapter with a behavioural RAM and a response scoreboard.
// Inputs change at posedge+1; DUT outputs are sampled on the falling edge.
module tb_sky130_ram_1p_host_adapter;

  localparam int Width = 32;
  localparam int Depth = 512;
  localparam int RspDepth = 2;
  localparam int Aw = 9;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_i = 1'b0;
  logic             we_i = 1'b0;
  logic [Aw-1:0]    addr_i = '0;
  logic [Width-1:0] wdata_i = '0;
  logic [Width-1:0] wmask_i = '0;
  logic             rready_i = 1'b1;
  logic             gnt_o, rvalid_o, ram_req_o, ram_write_o;
  logic [Width-1:0] rdata_o, ram_wdata_o, ram_wmask_o;
  logic [Aw-1:0]    ram_addr_o;
  logic [Width-1:0] ramRdata = '0;

  int total = 0;
  int bad = 0;
  int rspCount = 0;

  logic [Width-1:0] ramMem [Depth];
  logic [Width-1:0] refMem [Depth];
  logic [Width-1:0] expQ [$];

  logic             granted, lastReq, lastWrite, preReq, preWrite;
  logic [Width-1:0] lastWdata, lastWmask;
  logic [Aw-1:0]    lastAddr, preAddr;
  int               waitCycles;
  logic             prevWait = 1'b0;

  sky130_ram_1p_host_adapter #(
    .Width(Width),
    .Depth(Depth),
    .RspDepth(RspDepth)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .wmask_i    (wmask_i),
    .rvalid_o   (rvalid_o),
    .rready_i   (rready_i),
    .rdata_o    (rdata_o),
    .ram_req_o  (ram_req_o),
    .ram_write_o(ram_write_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_wmask_o(ram_wmask_o),
    .ram_rdata_i(ramRdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural single-port RAM: bit-masked write, registered read data.
  always @(posedge clk) begin
    if (ram_req_o) begin
      if (ram_write_o) begin
        ramMem[ram_addr_o] <= (ramMem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
      end else begin
        ramRdata <= ramMem[ram_addr_o];
      end
    end
  end

  // Scoreboard: grants push host-level expectations, accepted responses pop them.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (rvalid_o && rready_i) begin
        checkOutput("sbNonEmpty", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          checkOutput("rsp", rdata_o, expQ.pop_front());
        end
        rspCount++;
      end
      if (gnt_o) begin
        if (we_i) begin
          refMem[addr_i] = (refMem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
          expQ.push_back('0);
        end else begin
          expQ.push_back(refMem[addr_i]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_ni && prevWait) begin
      assert (req_i) else $error("[TB] FAIL reqDrop req_i=0 required=1");
    end
    prevWait <= rst_ni && req_i && !gnt_o;
  end

  // Called at posedge+1; returns at posedge+1 after the granting edge.
  task automatic applyStimulus(input logic we, input logic [Aw-1:0] a,
                               input logic [31:0] d, input logic [31:0] m, input int maxWait);
    req_i = 1'b1;
    we_i = we;
    addr_i = a;
    wdata_i = d;
    wmask_i = m;
    waitCycles = 0;
    granted = 1'b0;
    preReq = 1'b0;
    preWrite = 1'b0;
    preAddr = '0;
    for (int i = 0; i <= maxWait; i++) begin
      @(negedge clk);
      if (gnt_o) begin
        granted = 1'b1;
        lastReq = ram_req_o;
        lastWrite = ram_write_o;
        lastAddr = ram_addr_o;
        lastWdata = ram_wdata_o;
        lastWmask = ram_wmask_o;
        break;
      end
      preReq = ram_req_o;
      preWrite = ram_write_o;
      preAddr = ram_addr_o;
      waitCycles++;
      @(posedge clk); #1;
    end
    if (granted) begin
      @(posedge clk); #1;
    end
    checkOutput("granted", 32'(granted), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    req_i = 1'b0;
    we_i = 1'b0;
    wmask_i = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    idleCycles(3);
    for (int i = 0; i < 30 && expQ.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int grants;
    int idx;
    int totalWait;
    int startCount;
    logic [31:0] orig;

    for (int i = 0; i < Depth; i++) begin
      ramMem[i] = 32'h5A5A0000 ^ (i * 32'h01010101);
      refMem[i] = 32'h5A5A0000 ^ (i * 32'h01010101);
    end

    // Reset held with a pending read: nothing may leak out.
    repeat (2) @(posedge clk);
    #1;
    req_i = 1'b1;
    addr_i = 9'd3;
    @(negedge clk);
    checkOutput("rstGnt", 32'(gnt_o), 32'd0);
    checkOutput("rstRamReq", 32'(ram_req_o), 32'd0);
    @(posedge clk); #1;
    req_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("rstRvalid", 32'(rvalid_o), 32'd0);
    checkOutput("rstRdata", rdata_o, 32'd0);
    checkOutput("rstRamWrite", 32'(ram_write_o), 32'd0);
    @(posedge clk); #1;

    // Full write then read of the same word.
    applyStimulus(1'b1, 9'd5, 32'hDEADBEEF, 32'hFFFFFFFF, 4);
    checkOutput("wrWait", 32'(waitCycles), 32'd0);
    checkOutput("wrRamWrite", 32'({lastReq, lastWrite}), 32'd3);
    checkOutput("wrWmask", lastWmask, 32'hFFFFFFFF);
    applyStimulus(1'b0, 9'd5, 32'd0, 32'd0, 4);
    checkOutput("rdWait", 32'(waitCycles), 32'd0);
    checkOutput("rdRamRead", 32'({lastReq, lastWrite}), 32'd2);
    req_i = 1'b0;
    @(negedge clk);
    checkOutput("wrRspValid", 32'(rvalid_o), 32'd1);
    checkOutput("wrRspData", rdata_o, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rdT2Valid", 32'(rvalid_o), 32'd1);
    checkOutput("rdT2Data", rdata_o, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Partial-byte write becomes read then merged write.
    applyStimulus(1'b1, 9'd7, 32'h11223344, 32'hFFFFFFFF, 4);
    applyStimulus(1'b1, 9'd7, 32'hAABBCCDD, 32'h00F0FF00, 4);
    checkOutput("rmwWait", 32'(waitCycles), 32'd1);
    checkOutput("rmwRead", 32'({preReq, preWrite}), 32'd2);
    checkOutput("rmwReadAddr", 32'(preAddr), 32'd7);
    checkOutput("rmwWrite", 32'({lastReq, lastWrite}), 32'd3);
    checkOutput("rmwAddr", 32'(lastAddr), 32'd7);
    checkOutput("rmwData", lastWdata, 32'h11B2CC44);
    checkOutput("rmwWmask", lastWmask, 32'h00FFFF00);
    applyStimulus(1'b0, 9'd7, 32'd0, 32'd0, 4);

    // Empty mask: granted, no RAM access, zero response.
    applyStimulus(1'b1, 9'd12, 32'hCAFEF00D, 32'h00000000, 4);
    checkOutput("noneRamReq", 32'(lastReq), 32'd0);
    applyStimulus(1'b0, 9'd12, 32'd0, 32'd0, 4);
    drain();

    // Backpressure: only RspDepth grants while responses are stalled.
    rready_i = 1'b0;
    grants = 0;
    idx = 0;
    req_i = 1'b1;
    we_i = 1'b0;
    addr_i = 9'd20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (gnt_o) grants++;
      @(posedge clk); #1;
      if (grants > idx) begin
        idx = grants;
        addr_i = 9'(20 + idx);
      end
    end
    checkOutput("bpGrants", 32'(grants), 32'd2);
    @(negedge clk);
    checkOutput("bpGntLow", 32'(gnt_o), 32'd0);
    checkOutput("bpHead", rdata_o, refMem[20]);
    @(posedge clk); #1;
    rready_i = 1'b1;
    for (int c = 0; c < 10 && grants < 4; c++) begin
      @(negedge clk);
      if (gnt_o) grants++;
      @(posedge clk); #1;
      if (grants > idx) begin
        idx = grants;
        addr_i = 9'(20 + idx);
      end
    end
    req_i = 1'b0;
    checkOutput("bpResume", 32'(grants), 32'd4);
    drain();

    // Streaming reads at full rate.
    totalWait = 0;
    startCount = rspCount;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 9'(100 + i), 32'd0, 32'd0, 4);
      totalWait += waitCycles;
    end
    checkOutput("streamWait", 32'(totalWait), 32'd0);
    drain();
    checkOutput("streamRsp", 32'(rspCount - startCount), 32'd8);

    // Reset asserted during the merge cycle.
    orig = ramMem[9];
    req_i = 1'b1;
    we_i = 1'b1;
    addr_i = 9'd9;
    wdata_i = 32'hFFFFFFFF;
    wmask_i = 32'h0000000F;
    @(negedge clk);
    checkOutput("rstRmwEntryGnt", 32'(gnt_o), 32'd0);
    checkOutput("rstRmwEntryRead", 32'({ram_req_o, ram_write_o}), 32'd2);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    req_i = 1'b0;
    @(negedge clk);
    checkOutput("rstMergeRamReq", 32'(ram_req_o), 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("rstMergeRvalid", 32'(rvalid_o), 32'd0);
    checkOutput("rstMergeMem", ramMem[9], orig);
    @(posedge clk); #1;
    applyStimulus(1'b0, 9'd9, 32'd0, 32'd0, 4);
    checkOutput("rstIdleWait", 32'(waitCycles), 32'd0);
    drain();

    checkOutput("sbLeft", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
